// File: rtl/spw_ulight_nofifo_data_tx_writer_pkg.sv
// Shared constants and types for the uLight SpaceWire TX writer.
// Register map, FSM state type and STATUS bit positions.
package spw_ulight_tx_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_STATUS = 2'd1;
   localparam logic [1:0] ADDR_CLEAR  = 2'd2;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_SEND = 1'b1
   } tx_state_t;

   localparam int ST_BUSY    = 0;
   localparam int ST_OVERRUN = 1;
   localparam int ST_TIMEOUT = 2;

endpackage

// File: rtl/spw_ulight_nofifo_data_tx_writer_if.sv
// Avalon-MM slave port plus the N-char link toward SpaceWire TX.
// slave = writer side, master = host/link side.
interface spw_ulight_nofifo_data_tx_writer_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic [8:0]  tx_data;
   logic        tx_write;
   logic        tx_ready;

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      input  tx_ready,
      output readdata,
      output tx_data,
      output tx_write
   );

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      output tx_ready,
      input  readdata,
      input  tx_data,
      input  tx_write
   );

endinterface

// File: rtl/spw_ulight_nofifo_data_tx_writer_timeout.sv
// SEND-stall watchdog: counts stalled SEND cycles.
// expired is combinational on the last allowed cycle.
module spw_ulight_tx_timeout #(
   parameter int unsigned CYCLES = 1024
) (
   input  logic clk,
   input  logic reset_n,
   input  logic run,
   input  logic clear,
   output logic expired
);

   localparam int unsigned W = (CYCLES > 2) ? $clog2(CYCLES) : 1;

   logic [W-1:0] cnt;

   assign expired = run && (cnt == W'(CYCLES - 1));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (clear || expired) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spw_ulight_nofifo_data_tx_writer.sv
// Avalon-MM to SpaceWire TX single-N-char writer, no FIFO.
// Define SPW_TX_TIMEOUT_EN to abort SEND after TIMEOUT_CYCLES stalls.
module spw_ulight_nofifo_data_tx_writer
   import spw_ulight_tx_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input logic clk,
   input logic reset_n,
   spw_ulight_nofifo_data_tx_writer_if.slave bus
);

   tx_state_t   state;
   tx_state_t   state_nx;
   logic [8:0]  tx_data_q;
   logic [31:0] rdata_q;
   logic [31:0] status;
   logic        wr;
   logic        wr_data;
   logic        wr_clear;
   logic        load;
   logic        ov_set;
   logic        to_set;
   logic        expired;
   logic        overrun_q;
   logic        timeout_q;

   assign wr       = bus.chipselect & ~bus.write_n;
   assign wr_data  = wr && (bus.address == ADDR_DATA);
   assign wr_clear = wr && (bus.address == ADDR_CLEAR);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      load     = 1'b0;
      ov_set   = 1'b0;
      to_set   = 1'b0;
      unique case (state)
         S_IDLE: begin
            if (wr_data) begin
               load     = 1'b1;
               state_nx = S_SEND;
            end
         end
         S_SEND: begin
            // a transfer frees the slot, so a same-cycle write chains on
            if (bus.tx_ready) begin
               if (wr_data) begin
                  load = 1'b1;
               end else begin
                  state_nx = S_IDLE;
               end
            end else begin
               ov_set = wr_data;
               if (expired) begin
                  to_set   = 1'b1;
                  state_nx = S_IDLE;
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_data_q <= '0;
      end else if (load) begin
         tx_data_q <= bus.writedata[8:0];
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         overrun_q <= 1'b0;
      end else if (ov_set) begin
         overrun_q <= 1'b1;
      end else if (wr_clear && bus.writedata[1]) begin
         overrun_q <= 1'b0;
      end
   end

`ifdef SPW_TX_TIMEOUT_EN
   spw_ulight_tx_timeout #(
      .CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset_n (reset_n),
      .run     ((state == S_SEND) && !bus.tx_ready),
      .clear   ((state != S_SEND) || bus.tx_ready),
      .expired (expired)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         timeout_q <= 1'b0;
      end else if (to_set) begin
         timeout_q <= 1'b1;
      end else if (wr_clear && bus.writedata[2]) begin
         timeout_q <= 1'b0;
      end
   end
`else
   assign expired   = 1'b0;
   assign timeout_q = 1'b0;

   wire unused_cfg = ^{to_set, bus.writedata[2], TIMEOUT_CYCLES};
`endif

   wire unused_hi = ^bus.writedata[31:9];

   always_comb begin
      status             = '0;
      status[ST_BUSY]    = (state == S_SEND);
      status[ST_OVERRUN] = overrun_q;
      status[ST_TIMEOUT] = timeout_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdata_q <= '0;
      end else begin
         unique case (bus.address)
            ADDR_DATA:   rdata_q <= {23'b0, tx_data_q};
            ADDR_STATUS: rdata_q <= status;
            default:     rdata_q <= '0;
         endcase
      end
   end

   assign bus.readdata = rdata_q;
   assign bus.tx_data  = tx_data_q;
   assign bus.tx_write = (state == S_SEND);

endmodule

// File: doc/spw_ulight_nofifo_data_tx_writer.md
SPW_ULIGHT_NOFIFO_DATA_TX_WRITER -- requirements
Module: spw_ulight_nofifo_data_tx_writer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: cycles allowed in SEND without tx_ready before abort (used only with SPW_TX_TIMEOUT_EN).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 address  input  2  Avalon-MM word address (0 DATA, 1 STATUS, 2 CLEAR, 3 reserved).
REQ-005 chipselect  input  1  Avalon-MM slave select.
REQ-006 write_n  input  1  Avalon-MM write strobe, active-low.
REQ-007 writedata  input  32  Avalon-MM write data.
REQ-008 readdata  output  32  registered Avalon-MM read data.
REQ-009 tx_data  output  9  SpaceWire N-char to link TX: bit 8 = control flag (EOP/EEP), bits 7:0 = data.
REQ-010 tx_write  output  1  N-char valid toward link TX.
REQ-011 tx_ready  input  1  link TX accepts tx_data in any cycle where tx_write and tx_ready are both high.

Function
REQ-012 Write strobe: wr = chipselect & ~write_n; every write completes in one cycle with no wait states.
REQ-013 FSM has two states: IDLE (tx_write=0) and SEND (tx_write=1).
REQ-014 IDLE with wr to address 0: tx_data loads writedata[8:0], FSM enters SEND next cycle.
REQ-015 SEND: tx_write and tx_data held stable until a transfer cycle (tx_write & tx_ready).
REQ-016 Transfer cycle without concurrent DATA write: FSM returns to IDLE next cycle.
REQ-017 Transfer cycle with concurrent DATA write: the new byte loads, FSM stays in SEND (back-to-back, one N-char per cycle maximum).
REQ-018 SEND, no transfer, DATA write: write is discarded, tx_data unchanged, sticky overrun flag set.
REQ-019 STATUS layout: bit0 busy (state==SEND), bit1 overrun, bit2 timeout, bits 31:3 zero.
REQ-020 Write to address 2: writedata[1] clears overrun, writedata[2] clears timeout; a set event in the same cycle wins over a clear.
REQ-021 readdata updated every cycle (clock enable constant 1) from mux of address: 0 -> {23'b0, tx_data}, 1 -> STATUS, 2/3 -> zero; one-cycle read latency; independent of chipselect.
REQ-022 Writes to address 1 or 3 have no effect.

Reset
REQ-023 reset_n low asynchronously forces: FSM IDLE, tx_write 0, tx_data 0, readdata 0, overrun 0, timeout 0, timeout counter 0.
REQ-024 Reset asserted during SEND drops tx_write immediately; the pending N-char is lost and not resent after release.

Configuration
REQ-025 Macro SPW_TX_TIMEOUT_EN defined: counter increments each SEND cycle without transfer, clears on transfer or IDLE; on reaching TIMEOUT_CYCLES-1 the FSM enters IDLE next cycle, tx_write drops, timeout flag sets.
REQ-026 Timeout and a simultaneous transfer in the same cycle: transfer takes priority, timeout flag not set.
REQ-027 Macro undefined: no counter logic, SEND waits indefinitely, STATUS bit2 reads 0, CLEAR bit2 ignored.

Structure
REQ-028 Shared package spw_ulight_tx_pkg holds the address constants (ADDR_DATA, ADDR_STATUS, ADDR_CLEAR), the FSM state type, and the STATUS bit indices.
REQ-029 Timeout counter is sub-module spw_ulight_tx_timeout (inputs: run, clear; output: expired), instantiated only when SPW_TX_TIMEOUT_EN is defined.

Verification
REQ-030 Reset, then write 0x0A5 to addr 0 with tx_ready=1 -> tx_write high for exactly 1 cycle with tx_data=0x0A5, then IDLE, STATUS reads 0.
REQ-031 Write 0x100 (EOP) with tx_ready=0 for 5 cycles, then 1 -> tx_write held 6 cycles, tx_data=0x100 stable throughout, one transfer.
REQ-032 Write 0x011 with tx_ready=0, then write 0x022 -> tx_data stays 0x011, STATUS=0x3; write 0x2 to addr 2 -> STATUS=0x1.
REQ-033 tx_ready=1 held, DATA writes 0x001,0x002,0x003 on consecutive cycles -> three consecutive transfer cycles in order, overrun stays 0.
REQ-034 Macro defined, TIMEOUT_CYCLES=16, tx_ready=0 -> tx_write drops after 16 SEND cycles, STATUS=0x4; macro undefined -> tx_write stays high 100+ cycles.
REQ-035 reset_n pulsed low mid-SEND -> tx_write and readdata 0 same cycle, STATUS=0 after release, no transfer follows.
